mips_prog_loader: RTL and testbench

Streaming program loader for the two-phase MIPS CPU. It accepts 32-bit instruction words over a valid/ready stream and writes them into consecutive instruction-memory locations starting at address 0. It holds the CPU out of execution while loading, then releases it and reports completion when the CPU halts. On silicon it replaces the bench-side hierarchical preloading of the CPU's `Mem`, `PC`, `HALTED` and `TAKEN_BRANCH`.

---
 rtl/mips_prog_loader_if.sv | 9 +
 rtl/mips_prog_loader.sv | 68 ++++++
 tb/tb_mips_prog_loader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mips_prog_loader_if.sv
// mips_prog_loader_if: 32-bit instruction-word stream (valid/ready/last)
interface mips_prog_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/mips_prog_loader.sv
// mips_prog_loader: streams a program into instruction memory, then releases the CPU and reports its halt
// Optional LOADER_HLT_DETECT_EN: an HLT opcode word also ends the load.
module mips_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  mips_prog_loader_if.slave   s,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                cpu_run,
  input  logic                cpu_halted,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     word_count
);
  typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, HALT} state_t;
  state_t state, nxt;
  logic hs, term, full, restart;
  assign s.s_ready = state == LOAD;
  assign cpu_run   = state == RUN || state == HALT;
  assign done      = state == HALT;
  assign hs        = s.s_valid && s.s_ready;
  assign restart   = (state == IDLE || state == HALT) && start;
  assign full      = word_count == (ADDR_W+1)'(MAX_WORDS - 1);
`ifdef LOADER_HLT_DETECT_EN
  assign term = s.s_last || s.s_data[31:26] == 6'h3f;
`else
  assign term = s.s_last;
`endif
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, HALT: nxt = start ? LOAD : state;
      LOAD:       nxt = !hs ? LOAD : term ? RELEASE : full ? IDLE : LOAD;
      RELEASE:    nxt = RUN;
      RUN:        nxt = cpu_halted ? HALT : RUN;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      state  <= nxt;
      mem_we <= hs;
      if (hs) begin
        mem_addr   <= word_count[ADDR_W-1:0];
        mem_wdata  <= s.s_data;
        word_count <= word_count + 1'b1;
      end
      if (restart) begin
        word_count <= '0;
        err        <= 1'b0;
      end else if (hs && !term && full) begin
        err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader: directed checks of load, release, halt, overflow and reset abort
module tb_mips_prog_loader;
  logic clk = 1'b0;
  logic rst_n, start, cpu_halted, start2;
  logic mem_we, cpu_run, done, err;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] word_count;
  logic mem_we2, cpu_run2, done2, err2;
  logic [9:0] mem_addr2;
  logic [31:0] mem_wdata2;
  logic [10:0] word_count2;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] img [16];
  logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                            32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
  logic [31:0] hlt_prog [4] = '{32'h0ce77800, 32'h00222000, 32'hfc000000, 32'h00832800};
`ifdef LOADER_HLT_DETECT_EN
  localparam bit HLT = 1'b1;
`else
  localparam bit HLT = 1'b0;
`endif
  mips_prog_loader_if bus ();
  mips_prog_loader_if bus2 ();
  mips_prog_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s(bus),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .cpu_halted(cpu_halted), .done(done), .err(err), .word_count(word_count));
  mips_prog_loader #(.MAX_WORDS(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .s(bus2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .cpu_run(cpu_run2), .cpu_halted(1'b0), .done(done2), .err(err2), .word_count(word_count2));
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we && mem_addr < 10'd16) img[mem_addr[3:0]] <= mem_wdata;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; cpu_halted = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    bus2.s_valid = 1'b0; bus2.s_data = '0; bus2.s_last = 1'b0;
    step(); step();
    chk("rst s_ready", bus.s_ready, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst cpu_run", cpu_run, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst word_count", word_count, 0);
    chk("rst mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    step();
    chk("idle s_ready", bus.s_ready, 0);
    // full-rate load of the 9-word program
    start = 1'b1; step(); start = 1'b0;
    chk("load s_ready", bus.s_ready, 1);
    for (int i = 0; i < 9; i++) begin
      bus.s_valid = 1'b1; bus.s_data = prog[i]; bus.s_last = (i == 8);
      step();
      chk($sformatf("ld%0d we", i), mem_we, 1);
      chk($sformatf("ld%0d addr", i), mem_addr, i);
      chk($sformatf("ld%0d data", i), mem_wdata, prog[i]);
      chk($sformatf("ld%0d cnt", i), word_count, i + 1);
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    chk("release s_ready", bus.s_ready, 0);
    chk("release cpu_run", cpu_run, 0);
    step();
    chk("run cpu_run", cpu_run, 1);
    chk("run we", mem_we, 0);
    chk("run done", done, 0);
    for (int i = 0; i < 9; i++) chk($sformatf("img%0d", i), img[i], prog[i]);
    cpu_halted = 1'b1; step(); cpu_halted = 1'b0;
    chk("halt done", done, 1);
    chk("halt cpu_run", cpu_run, 1);
    step();
    chk("halt hold", done, 1);
    // restart from HALT with a gapped stream
    start = 1'b1; step(); start = 1'b0;
    chk("restart done", done, 0);
    chk("restart cpu_run", cpu_run, 0);
    chk("restart s_ready", bus.s_ready, 1);
    chk("restart cnt", word_count, 0);
    for (int k = 0; k < 18; k++) begin
      bus.s_valid = (k % 2 == 0); bus.s_data = prog[k/2]; bus.s_last = (k / 2 == 8);
      step();
      if (k % 2 == 0) begin
        chk($sformatf("gap%0d we", k), mem_we, 1);
        chk($sformatf("gap%0d addr", k), mem_addr, k / 2);
        chk($sformatf("gap%0d data", k), mem_wdata, prog[k/2]);
      end else begin
        chk($sformatf("gap%0d idle we", k), mem_we, 0);
      end
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    chk("gap cpu_run", cpu_run, 1);
    chk("gap s_ready", bus.s_ready, 0);
    chk("gap cnt", word_count, 9);
    for (int i = 0; i < 9; i++) chk($sformatf("gap img%0d", i), img[i], prog[i]);
    cpu_halted = 1'b1; step(); cpu_halted = 1'b0;
    chk("gap done", done, 1);
    // HLT opcode mid-stream without s_last
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1; bus.s_data = hlt_prog[i]; bus.s_last = 1'b0;
      step();
      chk($sformatf("hlt%0d cnt", i), word_count, (HLT && i == 3) ? 3 : i + 1);
      if (i == 2) chk("hlt s_ready", bus.s_ready, HLT ? 0 : 1);
    end
    bus.s_valid = 1'b0;
    chk("hlt cpu_run", cpu_run, HLT ? 1 : 0);
    // overflow on a 4-word loader
    start2 = 1'b1; step(); start2 = 1'b0;
    chk("ovf s_ready", bus2.s_ready, 1);
    for (int i = 0; i < 5; i++) begin
      bus2.s_valid = 1'b1; bus2.s_data = prog[i]; bus2.s_last = 1'b0;
      step();
      if (i < 4) begin
        chk($sformatf("ovf%0d we", i), mem_we2, 1);
        chk($sformatf("ovf%0d addr", i), mem_addr2, i);
      end else begin
        chk("ovf5 we", mem_we2, 0);
      end
      if (i == 3) begin
        chk("ovf err", err2, 1);
        chk("ovf s_ready", bus2.s_ready, 0);
        chk("ovf cpu_run", cpu_run2, 0);
      end
    end
    bus2.s_valid = 1'b0;
    chk("ovf cnt", word_count2, 4);
    chk("ovf err hold", err2, 1);
    chk("ovf idle run", cpu_run2, 0);
    start2 = 1'b1; step(); start2 = 1'b0;
    chk("ovf err clear", err2, 0);
    chk("ovf cnt clear", word_count2, 0);
    // reset aborts a load in progress
    bus.s_valid = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1'b1; bus.s_data = prog[i]; bus.s_last = 1'b0;
      step();
    end
    chk("pre-abort cnt", word_count, 2);
    bus.s_data = prog[2];
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("abort s_ready", bus.s_ready, 0);
    chk("abort we", mem_we, 0);
    chk("abort cnt", word_count, 0);
    chk("abort addr", mem_addr, 0);
    chk("abort data", mem_wdata, 0);
    chk("abort cpu_run", cpu_run, 0);
    bus.s_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = prog[5];
    step();
    bus.s_valid = 1'b0;
    chk("reload addr", mem_addr, 0);
    chk("reload data", mem_wdata, prog[5]);
    chk("reload cnt", word_count, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
